// File: rtl/sm_bus_loader.sv
// Host byte-stream to system-bus initiator: 'W' / 'R' frames become single
// bus writes or reads, answered with an ACK, an ERR or four read-data bytes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a command byte
// ADDR      | collecting 4 address bytes, LSB first
// DATA      | collecting 4 write-data bytes straight into bWData
// WRITE     | single-cycle bus write strobe
// RD_WAIT   | holding bAddr for RD_WAIT cycles, then capturing bRData
// TX_DATA   | returning the 4 captured read bytes, LSB first
// TX_ACK    | returning ACK_BYTE after a write
// TX_ERR    | returning ERR_BYTE for an unknown command
module sm_bus_loader #(
   parameter int unsigned RD_WAIT  = 1,
   parameter logic [7:0]  CMD_WR   = 8'h57,
   parameter logic [7:0]  CMD_RD   = 8'h52,
   parameter logic [7:0]  ACK_BYTE = 8'h4B,
   parameter logic [7:0]  ERR_BYTE = 8'h3F
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rxData,
   input  logic        rxValid,
   output logic        rxReady,
   output logic [7:0]  txData,
   output logic        txValid,
   input  logic        txReady,
   output logic [31:0] bAddr,
   output logic        bWe,
   output logic [31:0] bWData,
   input  logic [31:0] bRData,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_WRITE,
      S_RD_WAIT,
      S_TX_DATA,
      S_TX_ACK,
      S_TX_ERR
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

   state_t      state, state_nxt;
   logic [1:0]  cnt, cnt_nxt;
   logic [3:0]  wcnt, wcnt_nxt;
   logic        is_wr, is_wr_nxt;
   logic [31:0] addr_sr, addr_sr_nxt;
   logic [31:0] rd_buf, rd_buf_nxt;
   logic [31:0] bAddr_nxt, bWData_nxt;
   logic        bWe_nxt;
   logic        rx_fire, tx_fire;

   assign rx_fire = rxValid & rxReady;
   assign tx_fire = txValid & txReady;
   assign busy    = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         wcnt    <= '0;
         is_wr   <= 1'b0;
         addr_sr <= '0;
         rd_buf  <= '0;
         bAddr   <= '0;
         bWData  <= '0;
         bWe     <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         wcnt    <= wcnt_nxt;
         is_wr   <= is_wr_nxt;
         addr_sr <= addr_sr_nxt;
         rd_buf  <= rd_buf_nxt;
         bAddr   <= bAddr_nxt;
         bWData  <= bWData_nxt;
         bWe     <= bWe_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      wcnt_nxt    = wcnt;
      is_wr_nxt   = is_wr;
      addr_sr_nxt = addr_sr;
      rd_buf_nxt  = rd_buf;
      bAddr_nxt   = bAddr;
      bWData_nxt  = bWData;
      bWe_nxt     = 1'b0;
      rxReady     = 1'b0;
      txValid     = 1'b0;
      txData      = '0;

      case (state)
         S_IDLE: begin
            rxReady = 1'b1;
            if (rx_fire) begin
               if (rxData == CMD_WR || rxData == CMD_RD) begin
                  is_wr_nxt = (rxData == CMD_WR);
                  state_nxt = S_ADDR;
               end else begin
                  state_nxt = S_TX_ERR;
               end
            end
         end

         S_ADDR: begin
            rxReady = 1'b1;
            if (rx_fire) begin
               addr_sr_nxt = {rxData, addr_sr[31:8]};
               cnt_nxt     = cnt + 2'd1;
               // bAddr only moves once the whole address is known
               if (cnt == 2'd3) begin
                  bAddr_nxt = {rxData, addr_sr[31:8]};
                  state_nxt = is_wr ? S_DATA : S_RD_WAIT;
               end
            end
         end

         S_DATA: begin
            rxReady = 1'b1;
            if (rx_fire) begin
               bWData_nxt = {rxData, bWData[31:8]};
               cnt_nxt    = cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state_nxt = S_WRITE;
               end
            end
         end

         S_WRITE: begin
            state_nxt = S_TX_ACK;
         end

         S_RD_WAIT: begin
            if (wcnt == WAIT_LAST) begin
               rd_buf_nxt = bRData;
               state_nxt  = S_TX_DATA;
            end else begin
               wcnt_nxt = wcnt + 4'd1;
            end
         end

         S_TX_DATA: begin
            txValid = 1'b1;
            case (cnt)
               2'd0:    txData = rd_buf[7:0];
               2'd1:    txData = rd_buf[15:8];
               2'd2:    txData = rd_buf[23:16];
               default: txData = rd_buf[31:24];
            endcase
            if (tx_fire) begin
               cnt_nxt = cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state_nxt = S_IDLE;
               end
            end
         end

         S_TX_ACK: begin
            txValid = 1'b1;
            txData  = ACK_BYTE;
            if (tx_fire) begin
               state_nxt = S_IDLE;
            end
         end

         S_TX_ERR: begin
            txValid = 1'b1;
            txData  = ERR_BYTE;
            if (tx_fire) begin
               state_nxt = S_IDLE;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // every state starts with fresh byte and wait counts
      if (state_nxt != state) begin
         cnt_nxt  = '0;
         wcnt_nxt = '0;
      end

      // registered strobe: high exactly while the FSM sits in WRITE
      bWe_nxt = (state_nxt == S_WRITE);
   end

endmodule

// File: tb/tb_sm_bus_loader.sv
// Bench for sm_bus_loader: frame-level reference model with expected-byte and
// expected-write queues, per-cycle compare, directed and random frames.
module tb_sm_bus_loader;

   localparam int RDW0 = 1;
   localparam int RDW1 = 3;
   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;
   localparam logic [7:0] ACK    = 8'h4B;
   localparam logic [7:0] ERR    = 8'h3F;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  rx_data  [2];
   logic        rx_valid [2];
   logic        rx_ready [2];
   logic [7:0]  tx_data  [2];
   logic        tx_valid [2];
   logic        tx_ready [2] = '{1'b1, 1'b1};
   logic [31:0] b_addr   [2];
   logic        b_we     [2];
   logic [31:0] b_wdata  [2];
   logic [31:0] b_rdata  [2];
   logic        busy     [2];

   always #5 clk = ~clk;

   sm_bus_loader #(.RD_WAIT(RDW0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .rxData(rx_data[0]), .rxValid(rx_valid[0]), .rxReady(rx_ready[0]),
      .txData(tx_data[0]), .txValid(tx_valid[0]), .txReady(tx_ready[0]),
      .bAddr(b_addr[0]), .bWe(b_we[0]), .bWData(b_wdata[0]), .bRData(b_rdata[0]),
      .busy(busy[0])
   );

   sm_bus_loader #(.RD_WAIT(RDW1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .rxData(rx_data[1]), .rxValid(rx_valid[1]), .rxReady(rx_ready[1]),
      .txData(tx_data[1]), .txValid(tx_valid[1]), .txReady(tx_ready[1]),
      .bAddr(b_addr[1]), .bWe(b_we[1]), .bWData(b_wdata[1]), .bRData(b_rdata[1]),
      .busy(busy[1])
   );

   int          vectors  = 0;
   int          errs     = 0;
   int          cur      = 0;
   int          cyc      = 0;
   int          rd_mode  = 0;
   logic [31:0] rd_const = 32'h0;
   int          rdy_mode = 0;
   int          hold     = 0;
   bit          frame_open = 1'b0;
   logic [7:0]  exp_tx_q [$];
   logic [63:0] exp_wr_q [$];
   logic [7:0]  tx_log   [$];
   int          we_cnt = 0;
   int          we_cyc = -1;
   int          tv_rise = -1;
   bit          hold_prev = 1'b0;
   bit          tv_prev = 1'b0;
   logic [7:0]  tx_prev = 8'h0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] hash(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, ~a[31:16]} + 32'h0101_0101;
   endfunction

   function automatic logic [31:0] gval(input int k);
      return (32'(k) * 32'h0101_0107) ^ 32'h1357_9BDF;
   endfunction

   // bus-side responder: read data source selected by rd_mode
   always_comb begin
      for (int u = 0; u < 2; u++) begin
         case (rd_mode)
            0:       b_rdata[u] = rd_const;
            1:       b_rdata[u] = hash(b_addr[u]);
            default: b_rdata[u] = gval(cyc);
         endcase
      end
   end

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void fail_line(string name, logic [63:0] act);
      vectors++;
      errs++;
      $display("FAIL %s: observed 0x%0h where nothing was expected (t=%0t)", name, act, $time);
   endfunction

   // per-cycle compare against the frame-level model
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("rx_ready", 64'(rx_ready[cur]), 64'(exp_tx_q.size() == 0 && exp_wr_q.size() == 0));
         chk("busy", 64'(busy[cur]),
             64'(frame_open || exp_tx_q.size() != 0 || exp_wr_q.size() != 0));
         if (b_we[cur]) begin
            we_cnt++;
            we_cyc = cyc;
            if (exp_wr_q.size() == 0) fail_line("bus_write_unexpected", {b_addr[cur], b_wdata[cur]});
            else chk("bus_write", {b_addr[cur], b_wdata[cur]}, exp_wr_q.pop_front());
         end
         if (tx_valid[cur] && !tv_prev) tv_rise = cyc;
         if (hold_prev) begin
            chk("tx_hold_valid", 64'(tx_valid[cur]), 64'd1);
            chk("tx_hold_data", 64'(tx_data[cur]), 64'(tx_prev));
         end
         if (tx_valid[cur] && tx_ready[cur]) begin
            tx_log.push_back(tx_data[cur]);
            if (exp_tx_q.size() == 0) fail_line("tx_unexpected", 64'(tx_data[cur]));
            else chk("tx_byte", 64'(tx_data[cur]), 64'(exp_tx_q.pop_front()));
         end
         hold_prev = tx_valid[cur] && !tx_ready[cur];
         tx_prev   = tx_data[cur];
         tv_prev   = tx_valid[cur];
      end else begin
         hold_prev = 1'b0;
         tv_prev   = 1'b0;
      end
   end

   // sink side: always ready, random, or 5-cycle stall per byte
   initial forever begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) if (u != cur) tx_ready[u] = 1'b1;
      case (rdy_mode)
         0: tx_ready[cur] = 1'b1;
         1: tx_ready[cur] = ($urandom_range(99, 0) < 60);
         default: begin
            if (tx_ready[cur]) begin
               tx_ready[cur] = 1'b0;
               hold = 0;
            end else if (tx_valid[cur]) begin
               if (hold >= 5) tx_ready[cur] = 1'b1;
               else hold++;
            end
         end
      endcase
   end

   initial begin
      #700000;
      $display("FAIL watchdog: time limit reached, %0d miscompares so far", errs);
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // returns at posedge+1 just after acceptance; acc = cycle of acceptance
   task automatic send_byte(input logic [7:0] b, output int acc);
      bit done;
      done = 1'b0;
      acc  = -1;
      rx_data[cur]  = b;
      rx_valid[cur] = 1'b1;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         if (rx_ready[cur]) begin
            done = 1'b1;
            acc  = cyc;
         end
      end
      if (!done) fail_line("rx_accept_timeout", 64'(b));
      @(posedge clk);
      #1;
      rx_valid[cur] = 1'b0;
      rx_data[cur]  = 8'($urandom);
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (exp_tx_q.size() == 0 && exp_wr_q.size() == 0 && !busy[cur]) break;
      end
      if (i == 3000) begin
         fail_line("idle_timeout", 64'(exp_tx_q.size()));
         exp_tx_q.delete();
         exp_wr_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input int gmin, input int gmax, output int acc);
      send_byte(CMD_WR, acc);
      frame_open = 1'b1;
      for (int k = 0; k < 4; k++) begin
         idle(int'($urandom_range(gmax, gmin)));
         send_byte(a[8*k +: 8], acc);
      end
      for (int k = 0; k < 4; k++) begin
         idle(int'($urandom_range(gmax, gmin)));
         send_byte(d[8*k +: 8], acc);
      end
      exp_wr_q.push_back({a, d});
      exp_tx_q.push_back(ACK);
      frame_open = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, input int gmin, input int gmax, output int acc);
      logic [31:0] v;
      int rdw;
      rdw = (cur == 1) ? RDW1 : RDW0;
      send_byte(CMD_RD, acc);
      frame_open = 1'b1;
      for (int k = 0; k < 4; k++) begin
         idle(int'($urandom_range(gmax, gmin)));
         send_byte(a[8*k +: 8], acc);
      end
      // data seen on the bus during the last of the rdw wait cycles
      case (rd_mode)
         0:       v = rd_const;
         1:       v = hash(a);
         default: v = gval(acc + rdw);
      endcase
      for (int k = 0; k < 4; k++) exp_tx_q.push_back(v[8*k +: 8]);
      frame_open = 1'b0;
   endtask

   task automatic do_bad(input logic [7:0] b);
      int acc;
      send_byte(b, acc);
      exp_tx_q.push_back(ERR);
   endtask

   task automatic chk_log4(string name, logic [31:0] exp);
      chk({name, "_count"}, 64'(tx_log.size()), 64'd4);
      if (tx_log.size() == 4)
         chk(name, {32'd0, tx_log[3], tx_log[2], tx_log[1], tx_log[0]}, {32'd0, exp});
   endtask

   task automatic chk_reset_outputs(string tag, int u);
      chk({tag, "_bAddr"},   64'(b_addr[u]),   64'd0);
      chk({tag, "_bWe"},     64'(b_we[u]),     64'd0);
      chk({tag, "_bWData"},  64'(b_wdata[u]),  64'd0);
      chk({tag, "_txData"},  64'(tx_data[u]),  64'd0);
      chk({tag, "_txValid"}, 64'(tx_valid[u]), 64'd0);
      chk({tag, "_rxReady"}, 64'(rx_ready[u]), 64'd1);
      chk({tag, "_busy"},    64'(busy[u]),     64'd0);
   endtask

   initial begin
      int acc;
      int we0;
      logic [7:0] bb;
      for (int u = 0; u < 2; u++) begin
         rx_valid[u] = 1'b0;
         rx_data[u]  = 8'h0;
      end
      #1 rst_n = 1'b0;
      #2;
      chk_reset_outputs("reset0", 0);
      chk_reset_outputs("reset1", 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // back-to-back write to the GPIO address
      we0 = we_cnt;
      do_write(32'h0000_beb0, 32'h0000_1234, 0, 0, acc);
      wait_done();
      chk("wr_pulse_count", 64'(we_cnt - we0), 64'd1);
      chk("wr_we_latency", 64'(we_cyc), 64'(acc + 1));
      chk("wr_ack_latency", 64'(tv_rise), 64'(acc + 2));
      chk("wr_bAddr", 64'(b_addr[0]), 64'h0000_beb0);
      chk("wr_bWData", 64'(b_wdata[0]), 64'h0000_1234);

      // back-to-back read, constant bus data
      rd_mode  = 0;
      rd_const = 32'hA5A5_00FF;
      tx_log.delete();
      we0 = we_cnt;
      do_read(32'h0000_beb0, 0, 0, acc);
      wait_done();
      chk_log4("rd_bytes", 32'hA5A5_00FF);
      chk("rd_valid_latency", 64'(tv_rise), 64'(acc + RDW0 + 1));
      chk("rd_no_write", 64'(we_cnt - we0), 64'd0);
      chk("rd_bAddr", 64'(b_addr[0]), 64'h0000_beb0);

      // same read with rx gaps of 3 and a stalled sink
      rdy_mode = 2;
      tx_log.delete();
      do_read(32'h0000_beb0, 3, 3, acc);
      wait_done();
      chk_log4("bp_bytes", 32'hA5A5_00FF);

      // unknown command holds off rx until ERR drains, then R parses normally
      we0 = we_cnt;
      tx_log.delete();
      do_bad(8'h00);
      idle(2);
      @(negedge clk);
      chk("err_rxReady", 64'(rx_ready[0]), 64'd0);
      chk("err_txValid", 64'(tx_valid[0]), 64'd1);
      chk("err_txData", 64'(tx_data[0]), 64'h3F);
      wait_done();
      rdy_mode = 0;
      do_read(32'h0000_beb0, 0, 0, acc);
      wait_done();
      chk("err_no_write", 64'(we_cnt - we0), 64'd0);
      chk("err_then_rd_count", 64'(tx_log.size()), 64'd5);

      // reset in the middle of a write frame
      we0 = we_cnt;
      send_byte(CMD_WR, acc);
      frame_open = 1'b1;
      send_byte(8'hb0, acc);
      send_byte(8'hbe, acc);
      @(posedge clk);
      #1 rst_n = 1'b0;
      frame_open = 1'b0;
      #1;
      chk_reset_outputs("midrst", 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tx_log.delete();
      do_bad(8'h00);
      wait_done();
      chk("midrst_resp_count", 64'(tx_log.size()), 64'd1);
      if (tx_log.size() == 1) chk("midrst_resp", 64'(tx_log[0]), 64'h3F);
      chk("midrst_no_write", 64'(we_cnt - we0), 64'd0);

      // random frames on the RD_WAIT=1 unit
      rd_mode  = 1;
      rdy_mode = 1;
      for (int n = 0; n < 40; n++) begin
         int kind;
         kind = int'($urandom_range(5, 0));
         if (kind <= 1) do_write($urandom, $urandom, 0, 3, acc);
         else if (kind <= 4) do_read($urandom, 0, 3, acc);
         else begin
            bb = 8'($urandom);
            if (bb == CMD_WR || bb == CMD_RD) bb = 8'h00;
            do_bad(bb);
         end
         wait_done();
      end

      // RD_WAIT=3 unit: bus data changes every cycle
      cur      = 1;
      rdy_mode = 0;
      rd_mode  = 2;
      idle(2);
      do_read(32'h0000_beb0, 0, 2, acc);
      wait_done();
      chk("rd3_valid_latency", 64'(tv_rise), 64'(acc + RDW1 + 1));
      rdy_mode = 1;
      for (int n = 0; n < 12; n++) begin
         rd_mode = (n % 2 == 0) ? 1 : 2;
         if ($urandom_range(2, 0) == 0) do_write($urandom, $urandom, 0, 2, acc);
         else do_read($urandom, 0, 2, acc);
         wait_done();
      end

      chk("end_tx_queue", 64'(exp_tx_q.size()), 64'd0);
      chk("end_wr_queue", 64'(exp_wr_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/sm_bus_loader.md
Name: sm_bus_loader

Overview:
- Bus initiator that drives the system data bus (bAddr/bWe/bWData/bRData) from a byte-stream command channel.
- Lets a host (UART front-end, debug bridge) poke and peek any bus-mapped peripheral or memory, e.g. GPIO at 0x0000beb0.
- Sits between the byte-stream source/sink and the bus address decoder, in place of or muxed with the CPU data port.

Parameters:
- RD_WAIT, 1, cycles bAddr is held before bRData is sampled on a read (legal 1..15).
- CMD_WR, 8'h57, command byte for a write.
- CMD_RD, 8'h52, command byte for a read.
- ACK_BYTE, 8'h4B, response byte after a completed write.
- ERR_BYTE, 8'h3F, response byte for an unknown command.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rxData  in  8  incoming command/payload byte.
- rxValid  in  1  rxData valid.
- rxReady  out  1  loader accepts rxData this cycle.
- txData  out  8  response byte.
- txValid  out  1  txData valid.
- txReady  in  1  sink accepts txData this cycle.
- bAddr  out  32  bus address (registered).
- bWe  out  1  bus write enable (registered).
- bWData  out  32  bus write data (registered).
- bRData  in  32  bus read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: async on rst_n low; all state returns to IDLE. bAddr=0, bWe=0, bWData=0, txData=0, txValid=0, rxReady=1, busy=0.
- A byte transfers on a rising edge with rxValid&rxReady (rx) or txValid&txReady (tx). Gaps of any length are legal on both sides.
- rxReady=1 only in IDLE, ADDR and DATA. Everywhere else it is 0.
- States:
  - IDLE: on accepted byte: CMD_WR or CMD_RD -> ADDR with byte count 0. Any other byte -> TX_ERR.
  - ADDR: accept 4 bytes, LSB first, into the address shift register. After the 4th: WR -> DATA; RD -> RD_WAIT with wait count 0.
  - DATA: accept 4 bytes, LSB first, into bWData. After the 4th -> WRITE.
  - WRITE: bWe=1 for exactly one cycle with bAddr/bWData stable -> TX_ACK.
  - RD_WAIT: bWe=0, bAddr stable for RD_WAIT cycles. On the edge ending the last wait cycle, bRData is captured into the read buffer -> TX_DATA with byte count 0.
  - TX_DATA: txData = read buffer byte[count], LSB first, held stable while txValid=1 until accepted. After the 4th accepted byte -> IDLE.
  - TX_ACK / TX_ERR: txData = ACK_BYTE / ERR_BYTE, txValid=1 until accepted -> IDLE.
- bAddr updates only when the 4th address byte is accepted. bWData updates only as data bytes are accepted. Both hold their values otherwise, including in IDLE.
- bWe is never high outside WRITE. No bus write occurs on reads or errors.
- Latency:
  - Write: bWe pulses the cycle after the 8th payload byte is accepted. txValid (ACK) rises the cycle after that.
  - Read: txValid rises RD_WAIT+1 cycles after the 4th address byte is accepted.
- Reset mid-frame: the partial frame is discarded and no bus write is issued. The next byte after reset is parsed as a command.
- No timeout: an incomplete frame waits indefinitely.
- Byte and wait counters are 2-bit and 4-bit respectively. Counters clear on every state entry.

Test Plan:
- Write: rx 57 b0 be 00 00 34 12 00 00 back-to-back -> exactly one cycle of bWe=1 with bAddr=0x0000beb0, bWData=0x00001234. Then tx 4B once; busy low afterward.
- Read: rx 52 b0 be 00 00 with bRData driven to 0xA5A500FF -> bWe stays 0, bAddr=0x0000beb0. tx FF 00 A5 A5 in order; first txValid at RD_WAIT+1 cycles after the last address byte.
- Backpressure/gaps: read as above with txReady low for 5 cycles per byte and rxValid dropped 3 cycles between bytes. Required: txData stable while txValid&!txReady, no byte lost or duplicated, identical response.
- Bad command: rx 00 -> tx 3F, no bus activity, rxReady=0 until 3F is accepted. Then rx 52 parses as a read command.
- Reset mid-frame: rx 57 b0 be, assert rst_n low for 1 cycle -> all outputs at reset values immediately (async). Then rx 00 -> tx 3F, proving the frame was discarded.
- RD_WAIT=3 build: bRData changes each cycle after the address is set; the captured value must be the one present in the 3rd wait cycle.
